// File: rtl/qstate_pair_sequencer.sv
// Walks a 2^N_QUBITS complex state vector in (i0, i1) pairs for one target
// qubit, feeds each pair to an external fixed-latency gate pipeline and writes
// the gate results back in place.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif

module qstate_pair_sequencer #(
  parameter int N_QUBITS = 3,
  parameter int GATE_LAT = 2,
  parameter int W        = `TOTAL_WIDTH,
  localparam int TW      = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TW-1:0]       target,
  input  logic                load_we,
  input  logic [N_QUBITS-1:0] load_addr,
  input  logic [W-1:0]        load_r,
  input  logic [W-1:0]        load_i,
  input  logic [N_QUBITS-1:0] rd_addr,
  output logic [W-1:0]        rd_r,
  output logic [W-1:0]        rd_i,
  output logic [W-1:0]        alpha_r,
  output logic [W-1:0]        alpha_i,
  output logic [W-1:0]        beta_r,
  output logic [W-1:0]        beta_i,
  output logic                pair_valid,
  input  logic [W-1:0]        new_alpha_r,
  input  logic [W-1:0]        new_alpha_i,
  input  logic [W-1:0]        new_beta_r,
  input  logic [W-1:0]        new_beta_i,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NA     = 1 << N_QUBITS;
  localparam int NPAIRS = 1 << (N_QUBITS - 1);
  localparam int PW     = (N_QUBITS > 1) ? N_QUBITS - 1 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                          state;
  logic [PW-1:0]                   p;
  logic [TW-1:0]                   tgt;
  logic [NA-1:0][W-1:0]            mem_r, mem_i;
  logic [GATE_LAT:0]               vld_pipe;
  logic [GATE_LAT:0][N_QUBITS-1:0] i0_pipe, i1_pipe;

  logic                tgt_ok, issue, fwd;
  logic [PW-1:0]       iss_p;
  logic [TW-1:0]       iss_t;
  logic [N_QUBITS-1:0] iss_i0, iss_i1;
  logic [W-1:0]        a_r, a_i, b_r, b_i;

  // Insert a zero at bit t of the pair counter to get the lower index.
  function automatic logic [N_QUBITS-1:0] pair_i0(input logic [PW-1:0] pp,
                                                  input logic [TW-1:0] tt);
    logic [N_QUBITS-1:0] pe, lo;
    pe = N_QUBITS'(pp);
    lo = (N_QUBITS'(1) << tt) - N_QUBITS'(1);
    return ((pe >> tt) << (32'(tt) + 1)) | (pe & lo);
  endfunction

  assign tgt_ok     = (32'(target) < N_QUBITS);
  assign pair_valid = vld_pipe[0];
  assign rd_r       = mem_r[rd_addr];
  assign rd_i       = mem_i[rd_addr];

  // Pick the pair to register this cycle; the first pair is issued straight
  // from IDLE so pair_valid rises the cycle after start is sampled. A host
  // load landing on the same edge is forwarded so the pass sees it.
  always_comb begin
    issue = 1'b0;
    iss_p = '0;
    iss_t = tgt;
    fwd   = (state == IDLE) && load_we;
    case (state)
      IDLE:    if (start && tgt_ok) begin
                 issue = 1'b1;
                 iss_t = target;
               end
      ISSUE:   if (p != PW'(NPAIRS - 1)) begin
                 issue = 1'b1;
                 iss_p = p + 1'b1;
               end
      default: ;
    endcase
    iss_i0 = pair_i0(iss_p, iss_t);
    iss_i1 = iss_i0 | (N_QUBITS'(1) << iss_t);
    a_r = (fwd && load_addr == iss_i0) ? load_r : mem_r[iss_i0];
    a_i = (fwd && load_addr == iss_i0) ? load_i : mem_i[iss_i0];
    b_r = (fwd && load_addr == iss_i1) ? load_r : mem_r[iss_i1];
    b_i = (fwd && load_addr == iss_i1) ? load_i : mem_i[iss_i1];
  end

  // Sequencer FSM with registered status flags and pair outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      p       <= '0;
      tgt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      alpha_r <= '0;
      alpha_i <= '0;
      beta_r  <= '0;
      beta_i  <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      if (issue) begin
        alpha_r <= a_r;
        alpha_i <= a_i;
        beta_r  <= b_r;
        beta_i  <= b_i;
      end
      case (state)
        IDLE: if (start) begin
          if (tgt_ok) begin
            tgt   <= target;
            p     <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end else begin
            err <= 1'b1;
          end
        end
        ISSUE: begin
          if (p == PW'(NPAIRS - 1)) state <= DRAIN;
          else                      p     <= p + 1'b1;
        end
        DRAIN: if (vld_pipe[GATE_LAT] && vld_pipe[GATE_LAT-1:0] == '0) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line tracking each issued pair until its gate result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      i0_pipe  <= '0;
      i1_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[GATE_LAT-1:0], issue};
      i0_pipe  <= {i0_pipe[GATE_LAT-1:0], iss_i0};
      i1_pipe  <= {i1_pipe[GATE_LAT-1:0], iss_i1};
    end
  end

  // Amplitude store: reset to |0>, gate write-back or idle host load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= '0;
      mem_i    <= '0;
      mem_r[0] <= W'(16);
    end else if (vld_pipe[GATE_LAT]) begin
      mem_r[i0_pipe[GATE_LAT]] <= new_alpha_r;
      mem_i[i0_pipe[GATE_LAT]] <= new_alpha_i;
      mem_r[i1_pipe[GATE_LAT]] <= new_beta_r;
      mem_i[i1_pipe[GATE_LAT]] <= new_beta_i;
    end else if (state == IDLE && load_we) begin
      mem_r[load_addr] <= load_r;
      mem_i[load_addr] <= load_i;
    end
  end

endmodule

// File: tb/tb_qstate_pair_sequencer.sv
// Bench for qstate_pair_sequencer with a Hadamard-like gate pipeline attached.
module tb_qstate_pair_sequencer;
  localparam int NQ = 3, GL = 2, W = 8, NA = 8, NP = 4;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, load_we = 1'b0;
  logic [1:0] target = '0;
  logic [NQ-1:0] load_addr = '0, rd_addr = '0;
  logic [W-1:0] load_r = '0, load_i = '0, rd_r, rd_i;
  logic [W-1:0] alpha_r, alpha_i, beta_r, beta_i;
  logic [W-1:0] new_alpha_r, new_alpha_i, new_beta_r, new_beta_i;
  logic pair_valid, busy, done, err;

  qstate_pair_sequencer #(.N_QUBITS(NQ), .GATE_LAT(GL), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .load_we(load_we), .load_addr(load_addr), .load_r(load_r), .load_i(load_i),
    .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i),
    .alpha_r(alpha_r), .alpha_i(alpha_i), .beta_r(beta_r), .beta_i(beta_i),
    .pair_valid(pair_valid),
    .new_alpha_r(new_alpha_r), .new_alpha_i(new_alpha_i),
    .new_beta_r(new_beta_r), .new_beta_i(new_beta_i),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Gate: (a+b)/sqrt2, (a-b)/sqrt2 with 181/256, truncated toward zero.
  function automatic logic [W-1:0] hgate(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s = sub ? (sa - sb) : (sa + sb);
    s = s * 181 / 256;
    return W'(s);
  endfunction

  logic [W-1:0] g_ar[GL], g_ai[GL], g_br[GL], g_bi[GL];
  always @(posedge clk) begin
    g_ar[0] <= hgate(alpha_r, beta_r, 1'b0);
    g_ai[0] <= hgate(alpha_i, beta_i, 1'b0);
    g_br[0] <= hgate(alpha_r, beta_r, 1'b1);
    g_bi[0] <= hgate(alpha_i, beta_i, 1'b1);
    for (int k = 1; k < GL; k++) begin
      g_ar[k] <= g_ar[k-1]; g_ai[k] <= g_ai[k-1];
      g_br[k] <= g_br[k-1]; g_bi[k] <= g_bi[k-1];
    end
  end
  assign new_alpha_r = g_ar[GL-1];
  assign new_alpha_i = g_ai[GL-1];
  assign new_beta_r  = g_br[GL-1];
  assign new_beta_i  = g_bi[GL-1];

  // Reference model: memory, snapshot at pass start, pair list, timing anchors.
  int mr[NA], mi[NA], sr[NA], si[NA], pl0[NP], pl1[NP];
  int s_cyc = -1, err_cyc = -100, last_c0 = 0;
  int last_ar = 0, last_ai = 0, last_br = 0, last_bi = 0;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_ground();
    for (int i = 0; i < NA; i++) begin mr[i] = 0; mi[i] = 0; end
    mr[0] = 16;
    s_cyc = -1; err_cyc = -100;
    last_ar = 0; last_ai = 0; last_br = 0; last_bi = 0;
  endtask

  // Pairs are the indices with target bit clear, ascending, and their partner.
  task automatic build_pairs(input int t);
    int k;
    k = 0;
    for (int i = 0; i < NA; i++)
      if (((i >> t) & 1) == 0) begin
        pl0[k] = i; pl1[k] = i + (1 << t); k++;
      end
  endtask

  task automatic apply_final();
    for (int k = 0; k < NP; k++) begin
      int a, b;
      a = pl0[k]; b = pl1[k];
      mr[a] = $signed(hgate(W'(sr[a]), W'(sr[b]), 1'b0));
      mi[a] = $signed(hgate(W'(si[a]), W'(si[b]), 1'b0));
      mr[b] = $signed(hgate(W'(sr[a]), W'(sr[b]), 1'b1));
      mi[b] = $signed(hgate(W'(si[a]), W'(si[b]), 1'b1));
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    int d;
    bit e_pv, e_busy, e_done, e_err;
    wait (chk_en);
    forever begin
      @(negedge clk);
      d = (s_cyc >= 0) ? cyc - s_cyc : -1;
      e_pv   = (d >= 1) && (d <= NP);
      e_busy = (d >= 1) && (d <= NP + GL);
      e_done = (d == NP + GL + 1);
      e_err  = (cyc == err_cyc + 1);
      if (e_done) apply_final();
      if (e_pv) begin
        last_ar = sr[pl0[d-1]]; last_ai = si[pl0[d-1]];
        last_br = sr[pl1[d-1]]; last_bi = si[pl1[d-1]];
      end
      chk("pair_valid", int'(pair_valid), int'(e_pv));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("alpha_r", $signed(alpha_r), last_ar);
      chk("alpha_i", $signed(alpha_i), last_ai);
      chk("beta_r", $signed(beta_r), last_br);
      chk("beta_i", $signed(beta_i), last_bi);
      if (!e_busy) begin
        chk("rd_r", $signed(rd_r), mr[rd_addr]);
        chk("rd_i", $signed(rd_i), mi[rd_addr]);
      end
      if (e_done) s_cyc = -1;
      rd_addr = rd_addr + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one cycle of start and/or load; mirror its accepted effect in the model.
  task automatic drive(input bit st, input int t, input bit ld, input int la, input int lr, input int li);
    bit acc;
    int c0;
    acc = (s_cyc < 0);
    start = st; target = 2'(t);
    load_we = ld; load_addr = NQ'(la); load_r = W'(lr); load_i = W'(li);
    c0 = cyc;
    tick();
    start = 1'b0; load_we = 1'b0;
    if (acc) begin
      if (ld) begin mr[la] = lr; mi[la] = li; end
      if (st) begin
        if (t < NQ) begin
          for (int i = 0; i < NA; i++) begin sr[i] = mr[i]; si[i] = mi[i]; end
          build_pairs(t);
          s_cyc = c0;
          last_c0 = c0;
        end else begin
          err_cyc = c0;
        end
      end
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (seen) chk("done_latency", cyc - last_c0, NP + GL + 1);
    else      chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    model_ground();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    model_ground();
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    repeat (9) tick();

    // Hadamard on qubit 0 from |0>.
    drive(1, 0, 0, 0, 0, 0);
    wait_done();
    repeat (9) tick();
    chk("m_t0_amp0", mr[0], 11);
    chk("m_t0_amp1", mr[1], 11);
    chk("m_t0_amp2", mr[2], 0);

    // Target 2 from |0>.
    hard_reset();
    drive(1, 2, 0, 0, 0, 0);
    chk("m_t2_pair0_i0", pl0[0], 0);
    chk("m_t2_pair0_i1", pl1[0], 4);
    wait_done();
    repeat (9) tick();
    chk("m_t2_amp0", mr[0], 11);
    chk("m_t2_amp4", mr[4], 11);

    // Target 1 from |3>.
    hard_reset();
    drive(0, 0, 1, 3, 16, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("m_t1_pair1_i0", pl0[1], 1);
    chk("m_t1_pair1_i1", pl1[1], 3);
    chk("m_t1_pair2_i0", pl0[2], 4);
    chk("m_t1_pair3_i1", pl1[3], 7);
    wait_done();
    repeat (9) tick();
    chk("m_t1_amp1", mr[1], 11);
    chk("m_t1_amp3", mr[3], -11);
    chk("m_t1_amp0", mr[0], 0);

    // Load together with start, then a stray start and a load while busy.
    drive(1, 0, 1, 0, -16, 8);
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 2, 50, 0);
    wait_done();
    repeat (9) tick();
    chk("m_ld_amp0_r", mr[0], -3);
    chk("m_ld_amp0_i", mi[0], 5);
    chk("m_ld_amp1_r", mr[1], -19);
    chk("m_ld_amp2_r", mr[2], -7);
    chk("m_ld_amp3_r", mr[3], 7);

    // Out-of-range target: error pulse only.
    drive(1, 3, 0, 0, 0, 0);
    repeat (9) tick();

    // Reset in the middle of a pass.
    drive(1, 0, 0, 0, 0, 0);
    tick(); tick();
    hard_reset();
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
